reg_writeback_arbiter: RTL and testbench

Write-side master for the register file. It merges single-cycle ALU results and variable-latency load results onto the one regfile write port (write1/write_data/regwrite). Load results are buffered in a small FIFO. A busy scoreboard tracks destinations of outstanding loads and feeds the hazard/stall logic.

---
 rtl/reg_writeback_arbiter.sv | 99 +++++++++
 tb/tb_reg_writeback_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Write-side master for the register file: merges single-cycle ALU results and
// FIFO-buffered load results onto one write port, and keeps the load busy scoreboard.
module reg_writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int RW        = $clog2(NREG),
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            alu_valid,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_issue,
  input  logic [RW-1:0]   ld_issue_rd,
  input  logic            ld_valid,
  input  logic [RW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            wb_we,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy,
  output logic [PW:0]     fifo_count,
  output logic            waw_err
);

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mem [FIFO_DEPTH];
  logic [PW-1:0]   head, tail;
  logic            full, empty, push, pop, take_alu, sel_vld, waw_hit;
  ent_t            sel;
  logic [NREG-1:0] busy_nxt;

  assign full      = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign ld_ready  = !full;
  assign alu_ready = !full;
  assign push      = ld_valid && !full;
  // A full FIFO pre-empts the ALU so memory returns can never deadlock.
  assign pop       = full || (!alu_valid && !empty);
  assign take_alu  = alu_valid && !full;
  assign sel_vld   = pop || take_alu;

  always_comb begin
    sel = '{rd: alu_rd, data: alu_data};
    if (pop) sel = mem[head];
  end

  // Clear before set so a same-cycle reissue of the popped rd stays busy.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[sel.rd] = 1'b0;
    if (ld_issue) busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign waw_hit = (take_alu && alu_rd != '0 && busy[alu_rd]) ||
                   (push && ld_rd != '0 && !busy[ld_rd]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      busy       <= '0;
      fifo_count <= '0;
      head       <= '0;
      tail       <= '0;
      waw_err    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      wb_we <= sel_vld && (sel.rd != '0);
      if (sel_vld && sel.rd != '0) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
      busy <= busy_nxt;
      if (push) begin
        mem[tail] <= '{rd: ld_rd, data: ld_data};
        tail      <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (waw_hit) waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios plus constrained-random traffic,
// checked every cycle against a queue-based reference model.
module tb_reg_writeback_arbiter;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_valid, alu_ready, ld_issue, ld_valid, ld_ready, wb_we, waw_err;
  logic [4:0]  alu_rd, ld_issue_rd, ld_rd, wb_rd;
  logic [31:0] alu_data, ld_data, wb_data, busy;
  logic [2:0]  fifo_count;

  reg_writeback_arbiter #(.XLEN(32), .NREG(32), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .fifo_count(fifo_count), .waw_err(waw_err)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  ent_t        q[$];
  logic [31:0] mbusy;
  logic        mwaw, mwe;
  logic [4:0]  mrd;
  logic [31:0] mdata;
  logic        alu_acc, ld_acc;
  logic [4:0]  outs[$];
  int          ncmp = 0, nerr = 0, maxcnt;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  // One clock: predict from pre-edge model state, advance, then compare.
  task automatic cycle();
    ent_t e;
    bit   have, full, pop;
    e = '0; have = 0; pop = 0;
    full    = (q.size() == DEPTH);
    alu_acc = alu_valid && !full;
    ld_acc  = ld_valid && !full;
    if (full || (!alu_valid && q.size() != 0)) begin e = q[0]; have = 1; pop = 1; end
    else if (alu_valid) begin e.rd = alu_rd; e.data = alu_data; have = 1; end
    @(posedge CLK);
    if (RST) begin
      q.delete(); mbusy = '0; mwaw = 0; mwe = 0; mrd = 0; mdata = 0;
      alu_acc = 0; ld_acc = 0;
    end else begin
      if ((alu_acc && alu_rd != 0 && mbusy[alu_rd]) ||
          (ld_acc && ld_rd != 0 && !mbusy[ld_rd])) mwaw = 1;
      if (pop) void'(q.pop_front());
      if (ld_acc) q.push_back('{rd: ld_rd, data: ld_data});
      if (pop && e.rd != 0) mbusy[e.rd] = 0;
      if (ld_issue && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1;
      mwe = have && e.rd != 0;
      if (mwe) begin mrd = e.rd; mdata = e.data; end
    end
    #1;
    chk("wb_we", 64'(wb_we), 64'(mwe));
    chk("wb_rd", 64'(wb_rd), 64'(mrd));
    chk("wb_data", 64'(wb_data), 64'(mdata));
    chk("busy", 64'(busy), 64'(mbusy));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("waw_err", 64'(waw_err), 64'(mwaw));
    chk("ld_ready", 64'(ld_ready), 64'(q.size() != DEPTH));
    chk("alu_ready", 64'(alu_ready), 64'(q.size() != DEPTH));
    if (fifo_count > maxcnt) maxcnt = fifo_count;
  endtask

  initial begin
    int li, r, idx;
    bit clash;
    mbusy = '0; mwaw = 0; mwe = 0; mrd = 0; mdata = 0; maxcnt = 0;

    // Reset with random inputs applied
    RST = 1;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      ld_issue = 1'($urandom); ld_issue_rd = 5'($urandom);
      ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom;
      cycle();
    end
    RST = 0; idle(); cycle();

    // ALU path, then an x0 write that must be dropped
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; cycle();
    chk("alu_wb_data", 64'(wb_data), 64'h0DEADBEEF);
    alu_rd = 0; alu_data = 32'h55AA55AA; cycle();
    chk("x0_dropped", 64'(wb_we), 64'h0);
    idle(); cycle();

    // Load path with scoreboard
    ld_issue = 1; ld_issue_rd = 7; cycle();
    chk("busy7_set", 64'(busy[7]), 64'h1);
    idle(); cycle(); cycle();
    ld_valid = 1; ld_rd = 7; ld_data = 32'h12345678; cycle();
    idle(); cycle();
    chk("ld_wb_data", 64'(wb_data), 64'h12345678);
    chk("busy7_clr", 64'(busy[7]), 64'h0);
    cycle();

    // Priority with continuous ALU traffic filling the FIFO
    for (int i = 1; i <= 4; i++) begin ld_issue = 1; ld_issue_rd = 5'(i); cycle(); end
    idle(); li = 0; maxcnt = 0;
    alu_valid = 1; alu_rd = 10; alu_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      ld_valid = (li < 4); ld_rd = 5'(li + 1); ld_data = $urandom;
      cycle();
      if (ld_acc) li++;
      if (alu_acc) begin alu_rd = 5'(10 + c % 8); alu_data = $urandom; end
    end
    chk("fifo_reached_full", 64'(maxcnt), 64'(DEPTH));
    idle();
    for (int c = 0; c < 6; c++) cycle();

    // Wrap-around: ten loads streamed through the FIFO
    for (int i = 0; i < 10; i++) begin ld_issue = 1; ld_issue_rd = 5'(11 + i); cycle(); end
    idle();
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_rd = 5'(11 + i); ld_data = $urandom; cycle();
    end
    idle(); cycle(); cycle();

    // Reissue of rd 9 in the cycle its pop clears it: set wins
    ld_issue = 1; ld_issue_rd = 9; cycle();
    idle(); cycle();
    ld_valid = 1; ld_rd = 9; ld_data = 32'hCAFE0009; cycle();
    idle(); ld_issue = 1; ld_issue_rd = 9; cycle();
    idle(); cycle();
    chk("busy9_set_wins", 64'(busy[9]), 64'h1);
    ld_valid = 1; ld_rd = 9; ld_data = 32'hCAFE1009; cycle();
    idle(); cycle(); cycle();

    // ALU write to a busy register flags waw_err, which then sticks
    ld_issue = 1; ld_issue_rd = 3; cycle();
    idle(); alu_valid = 1; alu_rd = 3; alu_data = 32'h33; cycle();
    idle(); cycle(); cycle();
    chk("waw_sticky", 64'(waw_err), 64'h1);

    // Build fifo_count=3, then reset mid-operation
    for (int i = 0; i < 3; i++) begin ld_issue = 1; ld_issue_rd = 5'(21 + i); cycle(); end
    idle(); alu_valid = 1; alu_rd = 0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_rd = 5'(21 + i); ld_data = $urandom; alu_data = $urandom; cycle();
    end
    chk("count_before_rst", 64'(fifo_count), 64'h3);
    idle(); RST = 1; cycle();
    chk("count_after_rst", 64'(fifo_count), 64'h0);
    RST = 0; cycle();
    chk("no_stale_write", 64'(wb_we), 64'h0);

    // Constrained-random traffic obeying the hold and scoreboard protocol
    outs.delete();
    for (int c = 0; c < 400; c++) begin
      if (!(alu_valid && !alu_acc)) begin
        r = $urandom_range(0, 31);
        if (mbusy[r]) r = 0;
        alu_valid = ($urandom_range(0, 2) != 0); alu_rd = 5'(r); alu_data = $urandom;
      end
      if (!(ld_valid && !ld_acc)) begin
        ld_valid = 0;
        if (outs.size() != 0 && $urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, outs.size() - 1);
          ld_valid = 1; ld_rd = outs[idx]; ld_data = $urandom;
          outs.delete(idx);
        end
      end
      ld_issue = 0;
      if (outs.size() < 8 && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(1, 31);
        clash = mbusy[r] || (alu_valid && alu_rd == 5'(r)) || (ld_valid && ld_rd == 5'(r));
        foreach (outs[k]) if (outs[k] == 5'(r)) clash = 1;
        if (!clash) begin ld_issue = 1; ld_issue_rd = 5'(r); outs.push_back(5'(r)); end
      end
      cycle();
    end
    idle();
    for (int c = 0; c < 8; c++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
